// File: rtl/rom_stream_reader.sv
// Streams a run of consecutive words from a single-port, one-cycle-latency ROM
// onto a valid/ready interface through a 2-entry buffer sized for that latency.
//
// state | meaning
// IDLE  | waiting for start; count=0 commands only pulse done
// READ  | issuing ROM reads while the buffer has room
// DRAIN | last read issued; waiting for buffer and in-flight read to empty
module rom_stream_reader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   count,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W:0]   remaining;
    logic              pending;
    logic              pend_last;
    logic [DATA_W-1:0] mem_data [2];
    logic              mem_last [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fcnt;
    logic [2:0]        inflight;
    logic              pop;
    logic              issue;

    assign inflight  = {1'b0, fcnt} + {2'b00, pending};
    assign out_valid = (fcnt != 2'd0);
    assign pop       = out_valid & out_ready;

    // A read may be issued into a full pipeline only if a word leaves this cycle.
    assign issue = (state == READ) && (remaining != '0) &&
                   ((inflight < 3'd2) || ((inflight == 3'd2) && pop));

    assign rom_en   = issue;
    assign rom_addr = issue ? next_addr : last_addr;
    assign out_data = mem_data[rd_ptr];
    assign out_last = out_valid & mem_last[rd_ptr];
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            next_addr <= '0;
            last_addr <= '0;
            remaining <= '0;
            pending   <= 1'b0;
            pend_last <= 1'b0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            fcnt      <= 2'd0;
            done      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data[i] <= '0;
                mem_last[i] <= 1'b0;
            end
        end else begin
            done    <= 1'b0;
            pending <= issue;

            if (issue) begin
                pend_last <= (remaining == (ADDR_W+1)'(1));
                last_addr <= next_addr;
                next_addr <= next_addr + 1'b1;
                remaining <= remaining - 1'b1;
            end

            if (pending) begin
                mem_data[wr_ptr] <= rom_data;
                mem_last[wr_ptr] <= pend_last;
                wr_ptr           <= ~wr_ptr;
            end

            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({pending, pop})
                2'b10:   fcnt <= fcnt + 2'd1;
                2'b01:   fcnt <= fcnt - 2'd1;
                default: fcnt <= fcnt;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            next_addr <= start_addr;
                            remaining <= count;
                            state     <= READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && (remaining == (ADDR_W+1)'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave on the edge that empties the buffer so done lands right after the last pop.
                    if (!pending && ((fcnt == 2'd0) || ((fcnt == 2'd1) && pop))) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench for rom_stream_reader with a behavioural registered ROM.
module tb_rom_stream_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] start_addr;
    logic [3:0] count;
    logic       rom_en;
    logic [2:0] rom_addr;
    logic [3:0] rom_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [3:0] rom [8];
    logic [4:0] exp_q [$];
    logic [4:0] got_q [$];
    logic [2:0] addr_log [$];
    int         first_cyc;
    int         done_cyc;
    int         stall_err;
    int         ovf_err;
    int         busy_hi;
    logic       busy_at_done;

    rom_stream_reader #(.ADDR_W(3), .DATA_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rom_en) rom_data <= rom[rom_addr];
    end

    // Drives one command (cycle 0 = cycle in which start is high) and records what the DUT does.
    task automatic run_stream(input logic [2:0] a, input logic [3:0] n, input bit bp, input bit extra);
        logic [5:0] pat = 6'b101001;
        int         outstanding = 0;
        bit         prev_stall = 0;
        bit         p;
        logic [4:0] prev_word = '0;
        got_q.delete();
        addr_log.delete();
        first_cyc = -1; done_cyc = -1; stall_err = 0; ovf_err = 0; busy_hi = 0; busy_at_done = 1'bx;
        for (int k = 0; k < int'(n); k++)
            exp_q.push_back({(k == int'(n) - 1), rom[(int'(a) + k) % 8]});
        @(posedge clk); #1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            start      = (c == 0) || (extra && c == 2);
            start_addr = (c == 0) ? a : a + 3'd1;
            count      = (c == 0) ? n : 4'd5;
            out_ready  = bp ? pat[c % 6] : 1'b1;
            @(negedge clk);
            p = out_valid && out_ready;
            if (busy) busy_hi++;
            if (prev_stall && (!out_valid || {out_last, out_data} !== prev_word)) stall_err++;
            if (rom_en) begin
                addr_log.push_back(rom_addr);
                if (outstanding - int'(p) >= 2) ovf_err++;
                outstanding++;
            end
            if (p) begin
                if (first_cyc < 0) first_cyc = c;
                got_q.push_back({out_last, out_data});
                outstanding--;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
            if (done) begin
                done_cyc = c;
                busy_at_done = busy;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({rom_en, rom_addr, out_valid, out_data, out_last, busy, done} !== 13'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b expected 0", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done});
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_full_sweep(input string tag);
        logic [4:0] e, g;
        run_stream(3'd0, 4'd8, 1'b0, 1'b0);
        total++;
        if (done_cyc !== 11) begin bad++; $display("FAIL %s_done_cycle: got %0d expected 11", tag, done_cyc); end
        total++;
        if (first_cyc !== 3) begin bad++; $display("FAIL %s_first_cycle: got %0d expected 3", tag, first_cyc); end
        total++;
        if (got_q.size() !== 8) begin bad++; $display("FAIL %s_word_count: got %0d expected 8", tag, got_q.size()); end
        total++;
        if (busy_at_done !== 1'b0) begin bad++; $display("FAIL %s_busy_at_done: got %b expected 0", tag, busy_at_done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 5'bx;
            total++;
            if (g !== e) begin bad++; $display("FAIL %s_word: got last/data %h expected %h", tag, g, e); end
        end
    endtask

    task automatic test_wrap;
        logic [4:0] e, g;
        run_stream(3'd6, 4'd4, 1'b0, 1'b0);
        total++;
        if (addr_log.size() !== 4) begin bad++; $display("FAIL wrap_read_count: got %0d expected 4", addr_log.size()); end
        for (int k = 0; k < 4 && k < addr_log.size(); k++) begin
            total++;
            if (addr_log[k] !== 3'((6 + k) % 8)) begin
                bad++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, addr_log[k], (6 + k) % 8);
            end
        end
        total++;
        if (got_q.size() !== 4) begin bad++; $display("FAIL wrap_word_count: got %0d expected 4", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 5'bx;
            total++;
            if (g !== e) begin bad++; $display("FAIL wrap_word: got last/data %h expected %h", g, e); end
        end
    endtask

    task automatic test_backpressure;
        logic [4:0] e, g;
        run_stream(3'd2, 4'd5, 1'b1, 1'b0);
        total++;
        if (done_cyc < 0) begin bad++; $display("FAIL bp_done: got no done expected done within budget"); end
        total++;
        if (stall_err !== 0) begin bad++; $display("FAIL bp_stall_hold: got %0d unstable cycles expected 0", stall_err); end
        total++;
        if (ovf_err !== 0) begin bad++; $display("FAIL bp_overflow_issue: got %0d bad reads expected 0", ovf_err); end
        total++;
        if (got_q.size() !== 5) begin bad++; $display("FAIL bp_word_count: got %0d expected 5", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 5'bx;
            total++;
            if (g !== e) begin bad++; $display("FAIL bp_word: got last/data %h expected %h", g, e); end
        end
    endtask

    task automatic test_zero_and_ignored;
        logic [4:0] e, g;
        run_stream(3'd5, 4'd0, 1'b0, 1'b0);
        total++;
        if (done_cyc !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
        total++;
        if (addr_log.size() !== 0) begin bad++; $display("FAIL zero_reads: got %0d expected 0", addr_log.size()); end
        total++;
        if (got_q.size() !== 0) begin bad++; $display("FAIL zero_words: got %0d expected 0", got_q.size()); end
        total++;
        if (busy_hi !== 0) begin bad++; $display("FAIL zero_busy: got %0d busy cycles expected 0", busy_hi); end

        run_stream(3'd1, 4'd3, 1'b0, 1'b1);
        total++;
        if (done_cyc !== 6) begin bad++; $display("FAIL ignored_done_cycle: got %0d expected 6", done_cyc); end
        total++;
        if (got_q.size() !== 3) begin bad++; $display("FAIL ignored_word_count: got %0d expected 3", got_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = (got_q.size() > 0) ? got_q.pop_front() : 5'bx;
            total++;
            if (g !== e) begin bad++; $display("FAIL ignored_word: got last/data %h expected %h", g, e); end
        end
    endtask

    task automatic test_reset_mid_run;
        int stray = 0;
        @(posedge clk); #1;
        start = 1'b1; start_addr = 3'd0; count = 4'd8; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rom_en, rom_addr, out_valid, out_data, out_last, busy, done} !== 13'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got %b expected 0", {rom_en, rom_addr, out_valid, out_data, out_last, busy, done});
        end
        repeat (4) begin
            @(negedge clk);
            if (out_valid || done || rom_en || busy) stray++;
        end
        total++;
        if (stray !== 0) begin bad++; $display("FAIL midreset_stray: got %0d active cycles expected 0", stray); end
        test_full_sweep("after_reset");
    endtask

    initial begin
        rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'hA; rom[3] = 4'h6;
        rom[4] = 4'h7; rom[5] = 4'hD; rom[6] = 4'h9; rom[7] = 4'hB;
        rom_data = '0;
        test_reset();
        test_full_sweep("sweep");
        test_wrap();
        test_backpressure();
        test_zero_and_ignored();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_stream_reader.md
# rom_stream_reader

Sequencer that sits directly in front of the single-port ROM. It drives the ROM's `en`/`addr` inputs and streams the registered read data out on a valid/ready interface. One `start` command reads a run of consecutive ROM words, wrapping at the top of the address space, and presents them in order with a last-word marker. The block tolerates arbitrary downstream backpressure without losing or duplicating words, despite the ROM's one-cycle read latency.

## Interface
- `ADDR_W`, 3, ROM address width; depth is 2^ADDR_W.
- `DATA_W`, 4, ROM word width.

- `clk`  in  1  rising-edge clock shared with the ROM.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; sampled only in IDLE.
- `start_addr`  in  ADDR_W  first ROM address of the run.
- `count`  in  ADDR_W+1  number of words to read, 0..2^ADDR_W.
- `rom_en`  out  1  to ROM `en`.
- `rom_addr`  out  ADDR_W  to ROM `addr`.
- `rom_data`  in  DATA_W  from ROM `data_out`; valid in the cycle after an `rom_en` cycle.
- `out_valid`  out  1  `out_data` holds a word.
- `out_ready`  in  1  consumer accepts the word.
- `out_data`  out  DATA_W  streamed word.
- `out_last`  out  1  qualifies the final word of the run; meaningful only while `out_valid`=1.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes.

## Operation
- **States:**
  - IDLE: waits for a command. `start`=1 latches `start_addr` and `count`.
    - If `count`>0, go to READ.
    - If `count`=0, issue no reads, emit no words, and pulse `done` the following cycle while staying in IDLE.
  - READ: issues reads. Leaves for DRAIN in the cycle after the last read is issued.
  - DRAIN: waits until the in-flight read has landed and the output buffer is empty. Then returns to IDLE with `done`=1 for one cycle.
- **Address sequencing:** `rom_addr` = `start_addr` + k mod 2^ADDR_W for the k-th read, with k = 0..count-1. Wraps from 2^ADDR_W-1 to 0.
- **Output buffer:** 2-entry FIFO holding ROM words.
  - A `pending` flag marks that the previous cycle issued a read.
  - When `pending`=1, `rom_data` is pushed into the FIFO at that clock edge.
- **Issue rule (`rom_en`=1):** in READ, when reads remain and (fifo_count + pending) < 2, or (fifo_count + pending) = 2 with a pop this cycle. This rule prevents FIFO overflow.
- **Idle ROM port:** `rom_en`=0 whenever no read is issued. `rom_addr` holds its last value.
- **Output handshake:**
  - Pop occurs when `out_valid` & `out_ready`.
  - `out_data` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` never drops without a pop.
- **out_last:** set on the word whose index is count-1.
- **busy:** high from the cycle after an accepted `start` with count>0 through the cycle before `done`. `busy`=0 in the `done` cycle.
- **Ignored inputs:** `start` while `busy`=1 is ignored. `start_addr`/`count` changes during a run have no effect.
- **Reset:** `rst`=1 at any point, including mid-run, does all of the following:
  - returns to IDLE;
  - clears the FIFO, `pending`, and the counters;
  - ignores any ROM data returning in the following cycle;
  - discards the aborted run with no `done`.

## Timing
- **Reset values:** `rom_en`=0, `rom_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- **Latency:** `start` accepted in cycle 0 gives:
  - cycle 1: first `rom_en`=1;
  - cycle 2: ROM data presented;
  - cycle 3: first `out_valid`=1.
- **Throughput:** with `out_ready` held 1, one word per cycle. A run of N words has its last word at cycle N+2.
- **done timing:** `done` pulses in the cycle after the last-word handshake. If that handshake occurs in cycle N+2, `done` is at cycle N+3.
- **Back-to-back runs:** the earliest next `start` is accepted in the `done` cycle.
- **count=0:** `start` in cycle 0 gives `done` in cycle 1 and `busy` stays 0.

## Test plan
Reference ROM contents, addresses 0..7: 1,3,A,6,7,D,9,B.

- **Full sweep:** `start_addr`=0, `count`=8, `out_ready`=1 → `out_data` 1,3,A,6,7,D,9,B in cycles 3..10. `out_last` on B. `done` at cycle 11.
- **Wrap:** `start_addr`=6, `count`=4 → 9,B,1,3. `out_last` on 3. `rom_addr` sequence 6,7,0,1.
- **Backpressure:** `start_addr`=2, `count`=5, `out_ready` toggling 1,0,0,1,0,1… → exactly A,6,7,D,9 in order, with no duplicates or drops. `out_data` holds steady while stalled. `rom_en` is never asserted when FIFO+pending would overflow.
- **Zero count and ignored start:**
  - `count`=0 → `done` one cycle later, no `rom_en`, no `out_valid`.
  - A second `start` during a 3-word run → ignored; exactly 3 words are emitted.
- **Reset mid-run:** `rst` asserted in cycle 5 of an 8-word run → next cycle all outputs are at reset values. A stale ROM word is not emitted. A new run after reset behaves per the full-sweep scenario.
